// File: rtl/board_neighbor_fetch.sv
// Board tile store reader: fetches a cell's own tile and its four neighbours
// (left, down, right, up) from the synchronous board RAM, one read per cycle,
// and presents the five tile codes together on a valid/ready response port.
module board_neighbor_fetch #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int COORD_W = 4,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_row,
    input  logic [COORD_W-1:0] req_col,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [3:0]         mem_rd_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [3:0]         tile,
    output logic [3:0]         left,
    output logic [3:0]         down,
    output logic [3:0]         right,
    output logic [3:0]         up,
    output logic               resp_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESP} state_t;

    state_t             state, state_next;
    logic [2:0]         slot;
    logic [COORD_W-1:0] row_q, col_q;
    logic               err_q;
    logic               pend;
    logic [2:0]         pend_slot;
    logic               req_off;
    logic               accept;
    logic               nb_on;
    logic [COORD_W-1:0] nb_row, nb_col;

    assign req_off = (32'(req_row) >= 32'(ROWS)) || (32'(req_col) >= 32'(COLS));
    assign accept  = (state == IDLE) && req_valid;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q;

    // Neighbour coordinate and on-board flag for the current fetch slot
    always_comb begin
        nb_row = row_q;
        nb_col = col_q;
        nb_on  = 1'b0;
        case (slot)
            3'd0: nb_on = 1'b1;
            3'd1: begin
                nb_col = col_q - COORD_W'(1);
                nb_on  = (col_q != '0);
            end
            3'd2: begin
                nb_row = row_q + COORD_W'(1);
                nb_on  = (32'(row_q) != 32'(ROWS - 1));
            end
            3'd3: begin
                nb_col = col_q + COORD_W'(1);
                nb_on  = (32'(col_q) != 32'(COLS - 1));
            end
            3'd4: begin
                nb_row = row_q - COORD_W'(1);
                nb_on  = (row_q != '0);
            end
            default: nb_on = 1'b0;
        endcase
    end

    // RAM strobe and address: only during FETCH and only for on-board cells
    always_comb begin
        mem_rd_en = (state == FETCH) && nb_on;
        mem_addr  = '0;
        if (mem_rd_en) begin
            mem_addr = ADDR_W'(nb_row) * ADDR_W'(COLS) + ADDR_W'(nb_col);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_off ? RESP : FETCH;
                end
            end
            FETCH: begin
                if (slot == 3'd4) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slot counter, pending-capture tracking and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= 3'd0;
            pend      <= 1'b0;
            pend_slot <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            slot      <= (state == FETCH) ? slot + 3'd1 : 3'd0;
            pend      <= mem_rd_en;
            pend_slot <= slot;
            if (accept) begin
                err_q <= req_off;
            end
        end
    end

    // Latched request coordinate; only meaningful after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            row_q <= req_row;
            col_q <= req_col;
        end
    end

    // Tile registers: cleared on accept, loaded one cycle after each issued read
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            tile  <= 4'd0;
            left  <= 4'd0;
            down  <= 4'd0;
            right <= 4'd0;
            up    <= 4'd0;
        end else if (pend) begin
            case (pend_slot)
                3'd0:    tile  <= mem_rd_data;
                3'd1:    left  <= mem_rd_data;
                3'd2:    down  <= mem_rd_data;
                3'd3:    right <= mem_rd_data;
                3'd4:    up    <= mem_rd_data;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/board_neighbor_fetch.md
Name: board_neighbor_fetch

Overview:
Reader side of the board tile store. It accepts a cell coordinate and reads the cell's own tile plus its four neighbours (left, down, right, up) from the synchronous board RAM, one read per cycle. It then presents the five 4-bit tile codes together on a valid/ready response port. The response feeds the force-move placement logic. Tile codes: 0 = empty, 1..6 = tile types, 7..15 = not used.

Parameters:
ROWS, 8, number of board rows
COLS, 8, number of board columns
COORD_W, 4, width of the row and column coordinate fields
ADDR_W, 6, board RAM address width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  coordinate request present
req_ready  out  1  block can accept a request
req_row  in  COORD_W  row of the target cell
req_col  in  COORD_W  column of the target cell
mem_rd_en  out  1  board RAM read strobe
mem_addr  out  ADDR_W  board RAM address = row*COLS + col
mem_rd_data  in  4  RAM read data; valid in the cycle after mem_rd_en
resp_valid  out  1  neighbour set valid
resp_ready  in  1  consumer accepts the response
tile  out  4  tile code of the target cell
left  out  4  tile code at (row, col-1)
down  out  4  tile code at (row+1, col)
right  out  4  tile code at (row, col+1)
up  out  4  tile code at (row-1, col)
resp_err  out  1  requested coordinate was off-board

Behaviour:
- Reset (rst=1 at a rising edge): state goes to IDLE. req_ready=1. resp_valid=0, resp_err=0, mem_rd_en=0, mem_addr=0. tile, left, down, right and up are all 0. Any request in flight is dropped and no response is produced.
- States: IDLE, FETCH (slot counter 0..4), DRAIN, RESP.
- IDLE: req_ready=1. When req_valid=1 at an edge, the block latches req_row and req_col and clears all five tile registers.
  - If req_row>=ROWS or req_col>=COLS: go to RESP with resp_err=1 and all tile outputs 0. No RAM reads are issued.
  - Otherwise: go to FETCH with slot 0 and resp_err=0.
- req_ready is 0 in every state except IDLE.
- FETCH slot order is fixed: 0=tile, 1=left, 2=down, 3=right, 4=up.
  - Each slot lasts exactly one cycle.
  - mem_rd_en=1 only if the slot's neighbour lies on the board. mem_addr is that neighbour's address.
  - Off-board neighbours are: left when col=0; right when col=COLS-1; up when row=0; down when row=ROWS-1. For these, mem_rd_en=0, mem_addr=0, and the slot's register stays 0.
- Capture: in the cycle after a slot that issued a read, mem_rd_data is written into that slot's register. Slots 0..3 are captured during FETCH slots 1..4. Slot 4 is captured during DRAIN.
- DRAIN: one cycle, mem_rd_en=0, then go to RESP.
- Latency: accepting edge E, then FETCH cycles E+1..E+5, DRAIN at E+6, resp_valid=1 in cycle E+7. The off-board request path asserts resp_valid in cycle E+1.
- RESP: resp_valid=1, and all outputs are held stable until resp_ready=1 at an edge; then go to IDLE. The next request can be accepted one cycle later; there is no back-to-back overlap.
- While not in RESP, the tile outputs hold their last values, but consumers must qualify them with resp_valid.
- mem_rd_en is never asserted outside FETCH. At most one read is issued per cycle.
- Corner cells issue 3 reads; edge cells (non-corner) issue 4; interior cells issue 5. Response latency is fixed at 7 cycles regardless.
- req_valid seen outside IDLE is ignored. The requester must hold the request until req_ready=1.
- mem_rd_data values 7..15 are passed through unchanged; this block does not validate them.

Test Plan:
- Interior cell (3,4); RAM (3,4)=5, (3,3)=1, (4,4)=2, (3,5)=3, (2,4)=6 -> mem_addr sequence 28,27,36,29,20 with mem_rd_en high for 5 cycles; resp_valid at E+7 with tile=5, left=1, down=2, right=3, up=6, resp_err=0.
- Corner cell (0,0); RAM (0,0)=4, (1,0)=2, (0,1)=1 -> mem_rd_en high only in slots 0, 2 and 3; response tile=4, left=0, down=2, right=1, up=0.
- Off-board request (8,2) -> resp_valid at E+1, resp_err=1, all tile outputs 0, mem_rd_en never asserted.
- Backpressure: hold resp_ready=0 for 10 cycles during RESP -> outputs constant and req_ready=0; on resp_ready=1, IDLE is entered and req_ready=1 the next cycle.
- Reset mid-FETCH: assert rst during slot 2 -> next cycle is IDLE, mem_rd_en=0, all outputs 0, no response; a new request after reset completes normally.
- Corner cell (7,7), all RAM cells empty (0) -> response all zeros with resp_err=0; reads issued only for tile, left and up.
